// File: rtl/jtframe_prog_pkg.sv
// Shared types and constants for the ROM-download to SDRAM programming bridge.
package jtframe_prog_pkg;

    typedef logic [1:0] bank_t;

    // prog_mask is active-low: MASK_LO enables the low byte of the word.
    localparam logic [1:0] MASK_LO   = 2'b10;
    localparam logic [1:0] MASK_HI   = 2'b01;
    localparam logic [1:0] MASK_NONE = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        GAP
    } state_t;

    function automatic logic [1:0] byte_mask(input logic odd);
        return odd ? MASK_HI : MASK_LO;
    endfunction

endpackage

// File: rtl/jtframe_prog_fifo.sv
// Small synchronous FIFO; a pop in the same cycle frees a slot for a push even when full.
module jtframe_prog_fifo #(
    parameter int W  = 8,
    parameter int AW = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam logic [AW:0] DEPTH = (AW+1)'(2**AW);

    logic [W-1:0]  mem [2**AW];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // NOTE: the storage array has no reset; pointers and count alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // NOTE: non-blocking assignments so every register here sees the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    assign full  = (count == DEPTH);
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

endmodule

// File: rtl/jtframe_prog_bridge.sv
// Bridges data_io ROM download bytes to the SDRAM programming port: header strip,
// bank/word mapping, stall buffering and the busy flag that holds the game in reset.
module jtframe_prog_bridge
    import jtframe_prog_pkg::*;
#(
    parameter int          SDRAMW    = 22,
    parameter int          HEADER    = 0,
    parameter logic [24:0] BA1_START = 25'h1ff_ffff,
    parameter logic [24:0] BA2_START = 25'h1ff_ffff,
    parameter logic [24:0] BA3_START = 25'h1ff_ffff,
    parameter int          FIFOW     = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              downloading,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    input  logic              ioctl_wr,
    output logic [SDRAMW-1:0] prog_addr,
    output logic [7:0]        prog_data8,
    output logic [1:0]        prog_mask,
    output logic [1:0]        prog_ba,
    output logic              prog_we,
    input  logic              prog_rdy,
    output logic              dwnld_busy,
    output logic              overflow
);

    localparam logic [24:0] HDR  = 25'(HEADER);
    localparam int          RELW = SDRAMW + 1;

    typedef struct packed {
        bank_t             ba;
        logic [SDRAMW-1:0] addr;
        logic [1:0]        mask;
        logic [7:0]        data;
    } entry_t;

    localparam int EW = $bits(entry_t);

    logic        s1_valid;
    logic [24:0] s1_off;
    logic [7:0]  s1_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_off   <= '0;
            s1_data  <= '0;
        end else begin
            s1_valid <= downloading && ioctl_wr && (ioctl_addr >= HDR);
            s1_off   <= ioctl_addr - HDR;
            s1_data  <= ioctl_dout;
        end
    end

    // Bank decode in priority order; rel keeps only the bits that address a word plus the byte select.
    bank_t           dec_ba;
    logic [RELW-1:0] dec_rel;

    // NOTE: every output gets a default first so no path through the block can infer a latch.
    always_comb begin
        dec_ba  = 2'd0;
        dec_rel = RELW'(s1_off);
        if (s1_off >= BA3_START) begin
            dec_ba  = 2'd3;
            dec_rel = RELW'(s1_off - BA3_START);
        end else if (s1_off >= BA2_START) begin
            dec_ba  = 2'd2;
            dec_rel = RELW'(s1_off - BA2_START);
        end else if (s1_off >= BA1_START) begin
            dec_ba  = 2'd1;
            dec_rel = RELW'(s1_off - BA1_START);
        end
    end

    logic   s2_valid;
    entry_t s2_entry;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_entry <= '0;
        end else begin
            s2_valid      <= s1_valid;
            s2_entry.ba   <= dec_ba;
            s2_entry.addr <= dec_rel[SDRAMW:1];
            s2_entry.mask <= byte_mask(dec_rel[0]);
            s2_entry.data <= s1_data;
        end
    end

    logic    fifo_full;
    logic    fifo_empty;
    logic    pop;
    entry_t  head;
    logic [EW-1:0] fifo_dout;

    jtframe_prog_fifo #(
        .W  (EW),
        .AW (FIFOW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (s2_valid),
        .din   (s2_entry),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign head = fifo_dout;

    state_t state;
    state_t state_nx;

    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    state_nx = WAIT;
                end
            end
            WAIT:    if (prog_rdy) state_nx = GAP;
            GAP:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Output registers only change on a pop, so they stay stable for the whole WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            prog_we    <= 1'b0;
            prog_addr  <= '0;
            prog_data8 <= '0;
            prog_mask  <= MASK_NONE;
            prog_ba    <= 2'd0;
        end else begin
            state   <= state_nx;
            prog_we <= (state_nx == WAIT);
            if (pop) begin
                prog_addr  <= head.addr;
                prog_data8 <= head.data;
                prog_mask  <= head.mask;
                prog_ba    <= head.ba;
            end
        end
    end

    // A push into a full FIFO survives only if the FSM pops in the same cycle.
    logic drop;
    logic downloading_l;

    assign drop = s2_valid && fifo_full && !pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            downloading_l <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            downloading_l <= downloading;
            if (downloading && !downloading_l) overflow <= 1'b0;
            else if (drop)                     overflow <= 1'b1;
        end
    end

    assign dwnld_busy = downloading || s1_valid || s2_valid || !fifo_empty || (state != IDLE);

endmodule

// File: tb/tb_jtframe_prog_bridge.sv
// Directed bench for jtframe_prog_bridge: header strip, bank mapping, stall buffering,
// overflow, drain after download end and reset during a pending write.
module tb_jtframe_prog_bridge;

    logic        clk;
    logic        rst;
    logic        downloading;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wr;
    logic        prog_rdy;

    logic [21:0] prog_addr;
    logic [7:0]  prog_data8;
    logic [1:0]  prog_mask;
    logic [1:0]  prog_ba;
    logic        prog_we;
    logic        dwnld_busy;
    logic        overflow;

    logic [21:0] b_prog_addr;
    logic [7:0]  b_prog_data8;
    logic [1:0]  b_prog_mask;
    logic [1:0]  b_prog_ba;
    logic        b_prog_we;
    logic        b_dwnld_busy;
    logic        b_overflow;

    int vectors    = 0;
    int miscompares = 0;

    logic [33:0] qa[$];
    logic [33:0] qb[$];

    jtframe_prog_bridge #(
        .SDRAMW (22),
        .HEADER (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .downloading (downloading),
        .ioctl_addr  (ioctl_addr),
        .ioctl_dout  (ioctl_dout),
        .ioctl_wr    (ioctl_wr),
        .prog_addr   (prog_addr),
        .prog_data8  (prog_data8),
        .prog_mask   (prog_mask),
        .prog_ba     (prog_ba),
        .prog_we     (prog_we),
        .prog_rdy    (prog_rdy),
        .dwnld_busy  (dwnld_busy),
        .overflow    (overflow)
    );

    jtframe_prog_bridge #(
        .SDRAMW    (22),
        .HEADER    (0),
        .BA1_START (25'h001_0000),
        .BA2_START (25'h002_0000),
        .BA3_START (25'h003_0000)
    ) dut_b (
        .clk         (clk),
        .rst         (rst),
        .downloading (downloading),
        .ioctl_addr  (ioctl_addr),
        .ioctl_dout  (ioctl_dout),
        .ioctl_wr    (ioctl_wr),
        .prog_addr   (b_prog_addr),
        .prog_data8  (b_prog_data8),
        .prog_mask   (b_prog_mask),
        .prog_ba     (b_prog_ba),
        .prog_we     (b_prog_we),
        .prog_rdy    (prog_rdy),
        .dwnld_busy  (b_dwnld_busy),
        .overflow    (b_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A write is accepted at the next rising edge when prog_we and prog_rdy are both high.
    always @(negedge clk) begin
        if (prog_we && prog_rdy)     qa.push_back({prog_ba, prog_addr, prog_mask, prog_data8});
        if (b_prog_we && prog_rdy)   qb.push_back({b_prog_ba, b_prog_addr, b_prog_mask, b_prog_data8});
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [33:0] ent(input logic [1:0] ba, input logic [21:0] addr,
                                        input logic [1:0] m, input logic [7:0] d);
        return {ba, addr, m, d};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [24:0] a, input logic [7:0] d);
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        tick(1);
        ioctl_wr   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        qa.delete();
        qb.delete();
    endtask

    initial begin
        rst         = 1'b1;
        downloading = 1'b0;
        ioctl_addr  = '0;
        ioctl_dout  = '0;
        ioctl_wr    = 1'b0;
        prog_rdy    = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(1);

        check("rst_we",   64'(prog_we),    64'd0);
        check("rst_addr", 64'(prog_addr),  64'd0);
        check("rst_data", 64'(prog_data8), 64'd0);
        check("rst_mask", 64'(prog_mask),  64'b11);
        check("rst_ba",   64'(prog_ba),    64'd0);
        check("rst_busy", 64'(dwnld_busy), 64'd0);
        check("rst_ovf",  64'(overflow),   64'd0);

        // Header bytes are dropped, then the first real byte shows the 3-cycle latency.
        downloading = 1'b1;
        tick(1);
        check("busy_dl", 64'(dwnld_busy), 64'd1);
        for (int a = 0; a < 16; a++) begin
            write_byte(25'(a), 8'(a));
            tick(1);
        end
        tick(10);
        check("hdr_no_write", 64'(qa.size()), 64'd0);

        write_byte(25'd16, 8'hA5);
        tick(1);
        check("lat_n1", 64'(prog_we), 64'd0);
        tick(1);
        check("lat_n2", 64'(prog_we), 64'd0);
        tick(1);
        check("lat_n3", 64'(prog_we),    64'd1);
        check("lat_addr", 64'(prog_addr), 64'd0);
        check("lat_mask", 64'(prog_mask), 64'b10);
        check("lat_data", 64'(prog_data8), 64'hA5);
        write_byte(25'd17, 8'h5A);
        tick(10);
        check("hdr_count", 64'(qa.size()), 64'd2);
        check("hdr_w0", 64'(qa[0]), 64'(ent(2'd0, 22'd0, 2'b10, 8'hA5)));
        check("hdr_w1", 64'(qa[1]), 64'(ent(2'd0, 22'd0, 2'b01, 8'h5A)));

        // Bank decode on the second instance.
        do_reset();
        write_byte(25'h001_0003, 8'h11);
        tick(8);
        write_byte(25'h000_FFFF, 8'h22);
        tick(8);
        write_byte(25'h003_0004, 8'h33);
        tick(8);
        write_byte(25'h002_0000, 8'h44);
        tick(8);
        check("bank_count", 64'(qb.size()), 64'd4);
        check("bank_ba1", 64'(qb[0]), 64'(ent(2'd1, 22'd1,      2'b01, 8'h11)));
        check("bank_ba0", 64'(qb[1]), 64'(ent(2'd0, 22'h7FFF,  2'b01, 8'h22)));
        check("bank_ba3", 64'(qb[2]), 64'(ent(2'd3, 22'd2,      2'b10, 8'h33)));
        check("bank_ba2", 64'(qb[3]), 64'(ent(2'd2, 22'd0,      2'b10, 8'h44)));

        // Stall: the head entry waits in the output registers while 8 more fill the FIFO.
        do_reset();
        downloading = 1'b0;
        tick(1);
        downloading = 1'b1;
        tick(1);
        prog_rdy = 1'b0;
        write_byte(25'd16, 8'hC0);
        tick(4);
        check("stall_head_we", 64'(prog_we), 64'd1);
        for (int k = 1; k <= 8; k++) begin
            write_byte(25'(16 + k), 8'(8'hC0 + k));
            tick(1);
        end
        tick(3);
        check("stall_level", 64'(dut.u_fifo.count), 64'd8);
        check("stall_ovf",   64'(overflow),         64'd0);

        // One accepted write lines the IDLE pop up with the push of byte C9 into the full FIFO.
        prog_rdy = 1'b1;
        write_byte(25'd25, 8'hC9);
        prog_rdy = 1'b0;
        tick(2);
        check("pushpop_level", 64'(dut.u_fifo.count), 64'd8);
        check("pushpop_ovf",   64'(overflow),         64'd0);
        check("pushpop_head",  64'(prog_data8),       64'hC1);

        write_byte(25'd26, 8'hCA);
        tick(4);
        check("drop_ovf",   64'(overflow),         64'd1);
        check("drop_level", 64'(dut.u_fifo.count), 64'd8);
        tick(10);
        prog_rdy = 1'b1;
        tick(40);
        check("stall_count", 64'(qa.size()), 64'd10);
        for (int k = 0; k < 10; k++) begin
            check($sformatf("stall_w%0d", k), 64'(qa[k]),
                  64'(ent(2'd0, 22'(k >> 1), k[0] ? 2'b01 : 2'b10, 8'(8'hC0 + k))));
        end
        check("ovf_sticky", 64'(overflow), 64'd1);
        downloading = 1'b0;
        tick(1);
        downloading = 1'b1;
        tick(1);
        check("ovf_clear_rise", 64'(overflow), 64'd0);

        // Download ends with 5 entries pending; busy stays up through the last GAP.
        do_reset();
        prog_rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            write_byte(25'(16 + k), 8'(8'h50 + k));
            tick(1);
        end
        tick(4);
        downloading = 1'b0;
        prog_rdy    = 1'b1;
        check("drain_busy0", 64'(dwnld_busy), 64'd1);
        tick(13);
        check("drain_gap_busy", 64'(dwnld_busy), 64'd1);
        check("drain_gap_we",   64'(prog_we),    64'd0);
        tick(1);
        check("drain_done_busy", 64'(dwnld_busy), 64'd0);
        check("drain_count",     64'(qa.size()),  64'd5);
        check("drain_last",      64'(qa[4]),      64'(ent(2'd0, 22'd2, 2'b10, 8'h54)));

        // Reset while a write is held in WAIT with one more entry queued.
        downloading = 1'b1;
        prog_rdy    = 1'b0;
        write_byte(25'd16, 8'h77);
        tick(1);
        write_byte(25'd17, 8'h88);
        tick(4);
        check("wait_we",    64'(prog_we),          64'd1);
        check("wait_level", 64'(dut.u_fifo.count), 64'd1);
        rst = 1'b1;
        tick(1);
        check("rstw_we",    64'(prog_we),          64'd0);
        check("rstw_level", 64'(dut.u_fifo.count), 64'd0);
        check("rstw_busy",  64'(dwnld_busy),       64'(downloading));
        rst = 1'b0;
        qa.delete();
        prog_rdy = 1'b1;
        tick(8);
        check("rstw_no_write", 64'(qa.size()), 64'd0);
        downloading = 1'b0;
        tick(1);
        check("rstw_idle_busy", 64'(dwnld_busy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
